// File: rtl/lenet_layer_scheduler.sv
// Frame sequencer: ping-pong c/d banks between CONV and FC engines, with per-engine watchdogs.
// Latency: handshake -> conv_start 1 cycle; conv_done -> fc_start 2 cycles; fc2_done -> frame_done 1 cycle.
// Backpressure: frame_ready drops while CONV runs, the write bank is not FREE, or a timeout is flagged.
module lenet_layer_scheduler #(
    parameter int                   FRAME_CNT_WIDTH = 16,
    parameter int                   WDT_WIDTH       = 20,
    parameter logic [WDT_WIDTH-1:0] WDT_LIMIT       = 20'hFFFFF
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       frame_valid,
    output logic                       frame_ready,
    output logic                       conv_start,
    output logic                       conv_buf,
    input  logic                       conv_done,
    output logic                       fc_start,
    output logic                       mem_sel,
    input  logic                       fc1_done,
    input  logic                       fc2_done,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       err_protocol
);

    typedef enum logic [1:0] {B_FREE, B_CONV, B_FULL, B_FC} bank_e;
    typedef enum logic       {C_IDLE, C_RUN} conv_e;
    typedef enum logic [1:0] {F_IDLE, F_FC1, F_FC2} fc_e;

    localparam logic [WDT_WIDTH-1:0]       WDT_ONE  = {{(WDT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WDT_WIDTH-1:0]       WDT_LAST = WDT_LIMIT - WDT_ONE;
    localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE  = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

    bank_e                bank_q [2];
    bank_e                bank_d [2];
    conv_e                c_q, c_d;
    fc_e                  f_q, f_d;
    logic                 wr_q, wr_d, rd_q, rd_d;
    logic [WDT_WIDTH-1:0] c_wdt_q, c_wdt_d, f_wdt_q, f_wdt_d;
    logic                 conv_start_d, conv_buf_d, fc_start_d, mem_sel_d, frame_done_d;
    logic                 err_timeout_d, err_protocol_d;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_d;
    logic                 hs;

    assign frame_ready = (c_q == C_IDLE) && (bank_q[wr_q] == B_FREE) && !err_timeout;
    assign busy        = (c_q != C_IDLE) || (f_q != F_IDLE) ||
                         (bank_q[0] != B_FREE) || (bank_q[1] != B_FREE);
    assign hs          = frame_valid && frame_ready;

    always_comb begin
        bank_d         = bank_q;
        c_d            = c_q;
        f_d            = f_q;
        wr_d           = wr_q;
        rd_d           = rd_q;
        c_wdt_d        = c_wdt_q;
        f_wdt_d        = f_wdt_q;
        conv_start_d   = 1'b0;
        fc_start_d     = 1'b0;
        frame_done_d   = 1'b0;
        conv_buf_d     = conv_buf;
        mem_sel_d      = mem_sel;
        frame_cnt_d    = frame_cnt;
        err_timeout_d  = err_timeout;
        err_protocol_d = err_protocol;

        // CONV engine: owns bank[wr_ptr] from handshake until conv_done
        if (hs) begin
            conv_start_d   = 1'b1;
            conv_buf_d     = wr_q;
            bank_d[wr_q]   = B_CONV;
            c_d            = C_RUN;
            c_wdt_d        = '0;
        end else if (c_q == C_RUN) begin
            if (c_wdt_q != WDT_LAST) c_wdt_d = c_wdt_q + WDT_ONE;
            if (conv_done) begin
                bank_d[wr_q] = B_FULL;
                wr_d         = ~wr_q;
                c_d          = C_IDLE;
            end
        end

        // FC engine: mem_sel is held from fc_start until the next fc_start
        case (f_q)
            F_IDLE: begin
                if (bank_q[rd_q] == B_FULL && !err_timeout) begin
                    fc_start_d   = 1'b1;
                    mem_sel_d    = ~rd_q;
                    bank_d[rd_q] = B_FC;
                    f_d          = F_FC1;
                    f_wdt_d      = '0;
                end
            end
            F_FC1: begin
                if (f_wdt_q != WDT_LAST) f_wdt_d = f_wdt_q + WDT_ONE;
                if (fc1_done) begin
                    bank_d[rd_q] = B_FREE;
                    rd_d         = ~rd_q;
                    f_d          = F_FC2;
                end
            end
            F_FC2: begin
                if (f_wdt_q != WDT_LAST) f_wdt_d = f_wdt_q + WDT_ONE;
                if (fc2_done) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt + CNT_ONE;
                    f_d          = F_IDLE;
                end
            end
            default: f_d = F_IDLE;
        endcase

        if ((c_q == C_RUN && c_wdt_q == WDT_LAST) || (f_q != F_IDLE && f_wdt_q == WDT_LAST))
            err_timeout_d = 1'b1;
        if ((conv_done && c_q != C_RUN) || (fc1_done && f_q != F_FC1) || (fc2_done && f_q != F_FC2))
            err_protocol_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            bank_q[0]    <= B_FREE;
            bank_q[1]    <= B_FREE;
            c_q          <= C_IDLE;
            f_q          <= F_IDLE;
            wr_q         <= 1'b0;
            rd_q         <= 1'b0;
            c_wdt_q      <= '0;
            f_wdt_q      <= '0;
            conv_start   <= 1'b0;
            conv_buf     <= 1'b0;
            fc_start     <= 1'b0;
            mem_sel      <= 1'b1;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            err_timeout  <= 1'b0;
            err_protocol <= 1'b0;
        end else begin
            bank_q       <= bank_d;
            c_q          <= c_d;
            f_q          <= f_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            c_wdt_q      <= c_wdt_d;
            f_wdt_q      <= f_wdt_d;
            conv_start   <= conv_start_d;
            conv_buf     <= conv_buf_d;
            fc_start     <= fc_start_d;
            mem_sel      <= mem_sel_d;
            frame_done   <= frame_done_d;
            frame_cnt    <= frame_cnt_d;
            err_timeout  <= err_timeout_d;
            err_protocol <= err_protocol_d;
        end
    end

endmodule

// File: tb/tb_lenet_layer_scheduler.sv
// Scoreboard bench: expected start/done pulses are queued by the script and popped by a negedge monitor.
module tb_lenet_layer_scheduler;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        frame_valid = 1'b0, conv_done = 1'b0, fc1_done = 1'b0, fc2_done = 1'b0;
    logic        frame_ready, conv_start, conv_buf, fc_start, mem_sel, frame_done, busy;
    logic        err_timeout, err_protocol;
    logic [15:0] frame_cnt;

    logic        w_srst = 1'b1;
    logic        w_frame_valid = 1'b0, w_conv_done = 1'b0, w_fc1_done = 1'b0, w_fc2_done = 1'b0;
    logic        w_frame_ready, w_conv_start, w_conv_buf, w_fc_start, w_mem_sel, w_frame_done, w_busy;
    logic        w_err_timeout, w_err_protocol;
    logic [15:0] w_frame_cnt;

    int cyc = 0;
    int checks = 0;
    int passes = 0;
    int t0, t1, w0;

    typedef struct { int cyc; int val; } ev_t;
    ev_t conv_q[$];
    ev_t fc_q[$];
    ev_t done_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lenet_layer_scheduler dut (
        .clk(clk), .srst(srst), .frame_valid(frame_valid), .frame_ready(frame_ready),
        .conv_start(conv_start), .conv_buf(conv_buf), .conv_done(conv_done),
        .fc_start(fc_start), .mem_sel(mem_sel), .fc1_done(fc1_done), .fc2_done(fc2_done),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy),
        .err_timeout(err_timeout), .err_protocol(err_protocol)
    );

    lenet_layer_scheduler #(.WDT_LIMIT(20'd100)) dut_wdt (
        .clk(clk), .srst(w_srst), .frame_valid(w_frame_valid), .frame_ready(w_frame_ready),
        .conv_start(w_conv_start), .conv_buf(w_conv_buf), .conv_done(w_conv_done),
        .fc_start(w_fc_start), .mem_sel(w_mem_sel), .fc1_done(w_fc1_done), .fc2_done(w_fc2_done),
        .frame_done(w_frame_done), .frame_cnt(w_frame_cnt), .busy(w_busy),
        .err_timeout(w_err_timeout), .err_protocol(w_err_protocol)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        checks++;
        $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
    endtask

    // Monitor: every pulse must match the head of its queue in cycle and payload
    always @(negedge clk) begin
        ev_t e;
        if (conv_start === 1'b1) begin
            if (conv_q.size() == 0) unexpected("conv_start");
            else begin
                e = conv_q.pop_front();
                chk("conv_start_cycle", cyc, e.cyc);
                chk("conv_buf", int'(conv_buf), e.val);
            end
        end
        if (fc_start === 1'b1) begin
            if (fc_q.size() == 0) unexpected("fc_start");
            else begin
                e = fc_q.pop_front();
                chk("fc_start_cycle", cyc, e.cyc);
                chk("mem_sel", int'(mem_sel), e.val);
            end
        end
        if (frame_done === 1'b1) begin
            if (done_q.size() == 0) unexpected("frame_done");
            else begin
                e = done_q.pop_front();
                chk("frame_done_cycle", cyc, e.cyc);
                chk("frame_cnt", int'(frame_cnt), e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int c);
        while (cyc < c) step();
    endtask

    task automatic exp_conv(input int c, input int v); ev_t e; e.cyc = c; e.val = v; conv_q.push_back(e); endtask
    task automatic exp_fc(input int c, input int v);   ev_t e; e.cyc = c; e.val = v; fc_q.push_back(e);   endtask
    task automatic exp_done(input int c, input int v); ev_t e; e.cyc = c; e.val = v; done_q.push_back(e); endtask

    task automatic frame_at(input int c); at(c); frame_valid = 1'b1; step(); frame_valid = 1'b0; endtask
    task automatic cd_at(input int c);    at(c); conv_done = 1'b1;   step(); conv_done = 1'b0;   endtask
    task automatic f1_at(input int c);    at(c); fc1_done = 1'b1;    step(); fc1_done = 1'b0;    endtask
    task automatic f2_at(input int c);    at(c); fc2_done = 1'b1;    step(); fc2_done = 1'b0;    endtask

    task automatic do_reset();
        srst = 1'b1;
        frame_valid = 1'b0; conv_done = 1'b0; fc1_done = 1'b0; fc2_done = 1'b0;
        step(); step();
        srst = 1'b0;
        t0 = cyc;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_frame_ready"}, int'(frame_ready), 1);
        chk({tag, "_conv_start"}, int'(conv_start), 0);
        chk({tag, "_fc_start"}, int'(fc_start), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_conv_buf"}, int'(conv_buf), 0);
        chk({tag, "_mem_sel"}, int'(mem_sel), 1);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err_timeout"}, int'(err_timeout), 0);
        chk({tag, "_err_protocol"}, int'(err_protocol), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Single frame
        do_reset();
        chk_reset("rst");
        exp_conv(t0 + 6, 0);
        frame_at(t0 + 5);
        chk("single_busy_run", int'(busy), 1);
        chk("single_ready_run", int'(frame_ready), 0);
        exp_fc(t0 + 52, 1);
        cd_at(t0 + 50);
        f1_at(t0 + 300);
        exp_done(t0 + 321, 1);
        f2_at(t0 + 320);
        at(t0 + 322);
        chk("single_busy_end", int'(busy), 0);

        // Three overlapped frames
        do_reset();
        exp_conv(t0 + 3, 0);
        frame_at(t0 + 2);
        exp_fc(t0 + 22, 1);
        cd_at(t0 + 20);
        exp_conv(t0 + 22, 1);
        frame_at(t0 + 21);
        cd_at(t0 + 40);
        at(t0 + 41);
        frame_valid = 1'b1;
        at(t0 + 45);
        chk("ovl_ready_stall", int'(frame_ready), 0);
        exp_conv(t0 + 62, 0);
        at(t0 + 60);
        fc1_done = 1'b1;
        step();
        fc1_done = 1'b0;
        step();
        frame_valid = 1'b0;
        exp_done(t0 + 71, 1);
        exp_fc(t0 + 72, 0);
        f2_at(t0 + 70);
        cd_at(t0 + 80);
        f1_at(t0 + 90);
        exp_done(t0 + 101, 2);
        exp_fc(t0 + 102, 1);
        f2_at(t0 + 100);
        f1_at(t0 + 110);
        exp_done(t0 + 121, 3);
        f2_at(t0 + 120);
        at(t0 + 122);
        chk("ovl_frame_cnt", int'(frame_cnt), 3);
        chk("ovl_busy_end", int'(busy), 0);

        // Backpressure, then simultaneous conv_done/fc1_done
        do_reset();
        exp_conv(t0 + 3, 0);
        frame_at(t0 + 2);
        exp_fc(t0 + 12, 1);
        cd_at(t0 + 10);
        exp_conv(t0 + 12, 1);
        frame_at(t0 + 11);
        cd_at(t0 + 20);
        at(t0 + 21);
        frame_valid = 1'b1;
        chk("bp_ready_full", int'(frame_ready), 0);
        at(t0 + 30);
        chk("bp_ready_hold", int'(frame_ready), 0);
        at(t0 + 40);
        chk("bp_ready_at_fc1", int'(frame_ready), 0);
        fc1_done = 1'b1;
        step();
        fc1_done = 1'b0;
        chk("bp_ready_freed", int'(frame_ready), 1);
        exp_conv(t0 + 42, 0);
        step();
        frame_valid = 1'b0;
        chk("bp_mem_sel_fc2a", int'(mem_sel), 1);
        at(t0 + 49);
        chk("bp_mem_sel_fc2b", int'(mem_sel), 1);
        at(t0 + 50);
        fc2_done = 1'b1;
        exp_done(t0 + 51, 1);
        exp_fc(t0 + 52, 0);
        step();
        fc2_done = 1'b0;
        chk("bp_mem_sel_done", int'(mem_sel), 1);
        at(t0 + 60);
        conv_done = 1'b1;
        fc1_done = 1'b1;
        step();
        conv_done = 1'b0;
        fc1_done = 1'b0;
        chk("sim_ready", int'(frame_ready), 1);
        exp_conv(t0 + 62, 1);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        exp_done(t0 + 71, 2);
        exp_fc(t0 + 72, 1);
        f2_at(t0 + 70);
        f1_at(t0 + 80);
        cd_at(t0 + 85);
        exp_done(t0 + 91, 3);
        exp_fc(t0 + 92, 0);
        f2_at(t0 + 90);
        f1_at(t0 + 100);
        exp_done(t0 + 111, 4);
        f2_at(t0 + 110);
        at(t0 + 112);
        chk("sim_busy_end", int'(busy), 0);
        chk("sim_err_protocol", int'(err_protocol), 0);
        chk("sim_frame_cnt", int'(frame_cnt), 4);

        // Stray done pulses
        f2_at(t0 + 115);
        chk("stray_fc2_err", int'(err_protocol), 1);
        chk("stray_fc2_cnt", int'(frame_cnt), 4);
        chk("stray_fc2_busy", int'(busy), 0);
        cd_at(t0 + 120);
        chk("stray_cd_ready", int'(frame_ready), 1);
        chk("stray_cd_busy", int'(busy), 0);

        // Reset in the middle of FC1
        do_reset();
        chk_reset("rst2");
        exp_conv(t0 + 3, 0);
        frame_at(t0 + 2);
        exp_fc(t0 + 12, 1);
        cd_at(t0 + 10);
        at(t0 + 20);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk_reset("midfc1");
        t1 = cyc;
        exp_conv(t1 + 2, 0);
        frame_at(t1 + 1);
        exp_fc(t1 + 11, 1);
        cd_at(t1 + 9);
        f1_at(t1 + 20);
        exp_done(t1 + 26, 1);
        f2_at(t1 + 25);
        at(t1 + 27);
        chk("midfc1_frame_cnt", int'(frame_cnt), 1);

        // Watchdog with a 100-cycle limit
        step();
        w_srst = 1'b0;
        w0 = cyc;
        chk("wdt_ready_rst", int'(w_frame_ready), 1);
        at(w0 + 2);
        w_frame_valid = 1'b1;
        step();
        w_frame_valid = 1'b0;
        chk("wdt_conv_start", int'(w_conv_start), 1);
        at(w0 + 102);
        chk("wdt_err_before", int'(w_err_timeout), 0);
        at(w0 + 103);
        chk("wdt_err_at_limit", int'(w_err_timeout), 1);
        at(w0 + 110);
        w_conv_done = 1'b1;
        step();
        w_conv_done = 1'b0;
        chk("wdt_ready_blocked", int'(w_frame_ready), 0);
        at(w0 + 112);
        chk("wdt_fc_blocked", int'(w_fc_start), 0);
        chk("wdt_busy_full", int'(w_busy), 1);
        chk("wdt_err_sticky", int'(w_err_timeout), 1);
        chk("wdt_no_proto_err", int'(w_err_protocol), 0);
        w_srst = 1'b1;
        step();
        w_srst = 1'b0;
        chk("wdt_err_cleared", int'(w_err_timeout), 0);
        chk("wdt_ready_after_rst", int'(w_frame_ready), 1);

        step(); step();
        chk("conv_q_drained", conv_q.size(), 0);
        chk("fc_q_drained", fc_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
